// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg
// Shared definitions for the CPU memory-side logic: the responder state
// encoding, the operation codes latched with each request, and the default
// widths used by mem_responder and mem_array.
package cpu_mem_pkg;

    // Responder sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

    // Operation latched when a request is accepted
    localparam logic MEM_OP_RD = 1'b0;
    localparam logic MEM_OP_WR = 1'b1;

    // Default geometry and timing
    localparam int DEFAULT_ADDR_W      = 9;
    localparam int DEFAULT_DATA_W      = 32;
    localparam int DEFAULT_WAIT_CYCLES = 1;

    // Wait-state counter width; it covers the full 0..15 wait-state range
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// mem_array
// Single-port synchronous word RAM with a registered read port and no reset.
// A write and a read of the same address in one cycle return the old word.
//
// Ports:
//   Clock  in   rising-edge clock
//   we     in   write enable
//   addr   in   word address (ADDR_W bits)
//   wdata  in   write data (DATA_W bits)
//   rdata  out  registered read data (DATA_W bits)
module mem_array
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              Clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge Clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder between MAR/MDR and main memory. Rising edges of the
// level strobes Read/Write start one operation, which runs through optional
// wait states, one array access and a one-cycle Ready pulse. Conflicting
// strobes are rejected with a one-cycle Err pulse.
//
// Ports:
//   Clock     in   rising-edge clock
//   Clear     in   synchronous active-high reset
//   Read      in   read request level
//   Write     in   write request level
//   Address   in   word address from MAR
//   Data_in   in   write data from MDR
//   Data_out  out  last completed read value
//   Ready     out  one-cycle completion pulse
//   Busy      out  high while an operation is in progress
//   Err       out  one-cycle pulse for a rejected conflicting request
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              Ready,
    output logic              Busy,
    output logic              Err
);

    mem_state_t state;
    mem_state_t state_next;

    logic                  rd_q;
    logic                  wr_q;
    logic                  rd_edge;
    logic                  wr_edge;
    logic                  conflict;
    logic                  accept_rd;
    logic                  accept_wr;

    logic                  op_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     data_q;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [DATA_W-1:0]     data_out_q;
    logic                  err_q;

    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_rdata;

    // A conflict is any rising edge seen while the other strobe is high,
    // which covers both simultaneous edges and an edge against a held strobe.
    assign rd_edge   = Read & ~rd_q;
    assign wr_edge   = Write & ~wr_q;
    assign conflict  = (rd_edge & Write) | (wr_edge & Read);
    assign accept_rd = rd_edge & ~Write;
    assign accept_wr = wr_edge & ~Read;

    // State register
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and array control. In IDLE the array is addressed straight
    // from Address so that, with no wait states, the registered read data is
    // already valid during ACCESS; afterwards the latched address is used.
    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        case (state)
            IDLE: begin
                ram_addr = Address;
                if (accept_rd || accept_wr) begin
                    state_next = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt <= WAIT_CNT_W'(1)) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                ram_we     = (op_q == MEM_OP_WR);
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Edge registers, request latch, wait counter and output registers.
    // The edge registers track the strobes in every state, so an edge that
    // arrives while busy is absorbed and never replayed later.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            op_q       <= MEM_OP_RD;
            addr_q     <= '0;
            data_q     <= '0;
            wait_cnt   <= '0;
            data_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_q  <= Read;
            wr_q  <= Write;
            err_q <= (state == IDLE) && conflict;

            if ((state == IDLE) && (accept_rd || accept_wr)) begin
                op_q     <= accept_wr ? MEM_OP_WR : MEM_OP_RD;
                addr_q   <= Address;
                data_q   <= Data_in;
                wait_cnt <= WAIT_CNT_W'(WAIT_CYCLES);
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
            end

            if ((state == ACCESS) && (op_q == MEM_OP_RD)) begin
                data_out_q <= ram_rdata;
            end
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .Clock (Clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    assign Data_out = data_out_q;
    assign Ready    = (state == DONE);
    assign Busy     = (state != IDLE);
    assign Err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Drives two responders (one wait state and three wait states) from shared
// strobes and compares handshake timing, read data and memory contents
// against a word-array model with latency WAIT_CYCLES+2.
module tb_mem_responder;

    localparam int W1 = 1;
    localparam int W3 = 3;

    logic        Clock = 1'b0;
    logic        clear1;
    logic        clear3;
    logic        Read;
    logic        Write;
    logic [8:0]  Address;
    logic [31:0] Data_in;

    logic [31:0] data_out1;
    logic        ready1;
    logic        busy1;
    logic        err1;
    logic [31:0] data_out3;
    logic        ready3;
    logic        busy3;
    logic        err3;

    // Reference model: per-DUT word array and expected Data_out
    logic [31:0] mem1_m [64];
    logic [31:0] mem3_m [64];
    logic [31:0] exp_dout1;
    logic [31:0] exp_dout3;

    int nvec = 0;
    int nmis = 0;

    always #5 Clock = ~Clock;

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(W1)) dut1 (
        .Clock    (Clock),
        .Clear    (clear1),
        .Read     (Read),
        .Write    (Write),
        .Address  (Address),
        .Data_in  (Data_in),
        .Data_out (data_out1),
        .Ready    (ready1),
        .Busy     (busy1),
        .Err      (err1)
    );

    mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(W3)) dut3 (
        .Clock    (Clock),
        .Clear    (clear3),
        .Read     (Read),
        .Write    (Write),
        .Address  (Address),
        .Data_in  (Data_in),
        .Data_out (data_out3),
        .Ready    (ready3),
        .Busy     (busy3),
        .Err      (err3)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request through both responders. hold = tick at which the strobe
    // drops; intrude = pulse Write during the wait states of a read.
    task automatic run_op(input bit is_wr, input int addr, input logic [31:0] data,
                          input int hold, input bit intrude);
        int r1 = 0, r3 = 0, b1 = 0, b3 = 0, e1 = 0, e3 = 0, at1 = -1, at3 = -1;
        logic [31:0] x1, x3;
        x1 = is_wr ? exp_dout1 : mem1_m[addr];
        x3 = is_wr ? exp_dout3 : mem3_m[addr];
        Read    = !is_wr;
        Write   = is_wr;
        Address = 9'(addr);
        Data_in = data;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (ready1) begin
                r1++;
                at1 = k;
                chk("ready_data1", data_out1, x1);
            end
            if (ready3) begin
                r3++;
                at3 = k;
                chk("ready_data3", data_out3, x3);
            end
            b1 += int'(busy1);
            b3 += int'(busy3);
            e1 += int'(err1);
            e3 += int'(err3);
            if (k == hold) begin
                Read  = 1'b0;
                Write = 1'b0;
            end
            if (intrude && k == 1) begin
                Write   = 1'b1;
                Address = 9'(addr);
                Data_in = ~data;
            end
            if (intrude && k == 2) begin
                Write = 1'b0;
            end
        end
        chk("ready_count1", 32'(r1), 32'd1);
        chk("ready_count3", 32'(r3), 32'd1);
        chk("latency1", 32'(at1), 32'(W1 + 2));
        chk("latency3", 32'(at3), 32'(W3 + 2));
        chk("busy_cycles1", 32'(b1), 32'(W1 + 2));
        chk("busy_cycles3", 32'(b3), 32'(W3 + 2));
        chk("err_count1", 32'(e1), 32'd0);
        chk("err_count3", 32'(e3), 32'd0);
        if (is_wr) begin
            mem1_m[addr] = data;
            mem3_m[addr] = data;
        end
        exp_dout1 = x1;
        exp_dout3 = x3;
        chk("dout_stable1", data_out1, exp_dout1);
        chk("dout_stable3", data_out3, exp_dout3);
    endtask

    // Directed sequence followed by randomized operations
    initial begin
        int r1, r3, at1, e1, e3;
        logic [31:0] old20;

        clear1  = 1'b1;
        clear3  = 1'b1;
        Read    = 1'b0;
        Write   = 1'b0;
        Address = '0;
        Data_in = '0;
        exp_dout1 = '0;
        exp_dout3 = '0;
        repeat (3) tick();
        clear1 = 1'b0;
        clear3 = 1'b0;
        tick();

        // Give every modelled word a known value; Data_out stays at reset 0
        for (int a = 0; a < 64; a++) begin
            run_op(1'b1, a, $urandom, 1, 1'b0);
        end
        run_op(1'b0, 6'h2A, 32'h0, 1, 1'b0);

        // Reset with Read held; the held strobe then counts as an edge
        clear1  = 1'b1;
        clear3  = 1'b1;
        Read    = 1'b1;
        Address = 9'h3F;
        tick();
        tick();
        chk("rst_ready1", 32'(ready1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);
        chk("rst_dout1", data_out1, 32'd0);
        chk("rst_ready3", 32'(ready3), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        chk("rst_dout3", data_out3, 32'd0);
        exp_dout1 = '0;
        exp_dout3 = '0;
        clear1 = 1'b0;
        clear3 = 1'b0;
        run_op(1'b0, 6'h3F, 32'h0, 3, 1'b0);

        // Write then read back
        run_op(1'b1, 6'h05, 32'hDEADBEEF, 1, 1'b0);
        run_op(1'b0, 6'h05, 32'h0, 1, 1'b0);

        // Read strobe held for 10 cycles
        run_op(1'b0, 6'h10, 32'h0, 10, 1'b0);

        // Write pulse during a read's wait states is ignored
        run_op(1'b0, 6'h01, 32'h0BADF00D, 1, 1'b1);
        run_op(1'b0, 6'h01, 32'h0, 1, 1'b0);

        // Simultaneous Read and Write edges
        r1 = 0; r3 = 0; e1 = 0; e3 = 0;
        Read    = 1'b1;
        Write   = 1'b1;
        Address = 9'h07;
        Data_in = 32'hAAAA5555;
        tick();
        chk("conflict_err1", 32'(err1), 32'd1);
        chk("conflict_err3", 32'(err3), 32'd1);
        chk("conflict_busy1", 32'(busy1), 32'd0);
        Read  = 1'b0;
        Write = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            r1 += int'(ready1);
            r3 += int'(ready3);
            e1 += int'(err1);
            e3 += int'(err3);
        end
        chk("conflict_ready1", 32'(r1), 32'd0);
        chk("conflict_ready3", 32'(r3), 32'd0);
        chk("conflict_err_len1", 32'(e1), 32'd0);
        chk("conflict_err_len3", 32'(e3), 32'd0);
        chk("conflict_dout1", data_out1, exp_dout1);
        run_op(1'b0, 6'h07, 32'h0, 1, 1'b0);

        // Reset of the three-wait-state responder during its wait states
        old20 = mem3_m[6'h20];
        r1 = 0; r3 = 0; at1 = -1;
        Write   = 1'b1;
        Address = 9'h20;
        Data_in = 32'h12345678;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (ready1) begin
                r1++;
                at1 = k;
            end
            r3 += int'(ready3);
            if (k == 2) begin
                chk("midrst_dout3", data_out3, 32'd0);
                chk("midrst_busy3", 32'(busy3), 32'd0);
            end
            if (k == 1) begin
                Write  = 1'b0;
                clear3 = 1'b1;
            end
            if (k == 2) begin
                clear3 = 1'b0;
            end
        end
        chk("midrst_ready1", 32'(r1), 32'd1);
        chk("midrst_latency1", 32'(at1), 32'(W1 + 2));
        chk("midrst_ready3", 32'(r3), 32'd0);
        mem1_m[6'h20] = 32'h12345678;
        exp_dout3 = '0;
        run_op(1'b0, 6'h20, 32'h0, 1, 1'b0);
        chk("midrst_prior3", mem3_m[6'h20], old20);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), $urandom,
                   int'($urandom_range(1, 4)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
